// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: buffers memory-stage results and retires one entry per commit to
// the register file, with CSR round-trips, precise exception/ERTN flushes and a retire counter.
module wb_commit_unit #(
   parameter int DATA_W = 32,
   parameter int EXC_W  = 16,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 64,
   localparam int IN_W  = 3*DATA_W + EXC_W + 23,
   localparam int IDX_W = $clog2(EXC_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_bus,
   output logic              csr_req,
   output logic              csr_we,
   output logic [13:0]       csr_num,
   output logic [DATA_W-1:0] csr_wdata,
   input  logic              csr_rvalid,
   input  logic [DATA_W-1:0] csr_rdata,
   output logic              excp_flush,
   output logic [IDX_W-1:0]  excp_idx,
   output logic              ertn_flush,
   output logic [DATA_W-1:0] epc,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              fwd_valid,
   output logic [4:0]        fwd_dest,
   output logic [DATA_W-1:0] fwd_data,
   output logic              fwd_pending,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_CSR_WAIT = 1'b1;

   logic [IN_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [0:0]       state_reg;
   logic [CNT_W-1:0] retire_cnt_reg;

   logic [IN_W-1:0]   head;
   logic [DATA_W-1:0] h_pc, h_result, h_csr_wdata;
   logic [4:0]        h_dest;
   logic              h_gr_we, h_res_csr, h_ertn, h_csr_we;
   logic [13:0]       h_csr_num;
   logic [EXC_W-1:0]  h_excp;

   assign head        = mem[rd_ptr_reg];
   assign h_pc        = head[0 +: DATA_W];
   assign h_result    = head[DATA_W +: DATA_W];
   assign h_dest      = head[2*DATA_W +: 5];
   assign h_gr_we     = head[2*DATA_W + 5];
   assign h_res_csr   = head[2*DATA_W + 6];
   assign h_ertn      = head[2*DATA_W + 7];
   assign h_csr_we    = head[2*DATA_W + 8];
   assign h_csr_num   = head[2*DATA_W + 9 +: 14];
   assign h_csr_wdata = head[2*DATA_W + 23 +: DATA_W];
   assign h_excp      = head[3*DATA_W + 23 +: EXC_W];

   // Gating by reset keeps every combinational output at zero while reset is held.
   logic head_valid, eval, has_excp, is_csr, full, flush_now;
   logic plain_commit, csr_commit, commit, push, csr_active;
   logic [IDX_W-1:0] excp_idx_c;

   assign head_valid   = !reset && (count_reg != '0);
   assign eval         = head_valid && (state_reg == S_IDLE);
   assign has_excp     = |h_excp;
   assign is_csr       = h_csr_we || h_res_csr;
   assign full         = count_reg == (PTR_W+1)'(DEPTH);

   assign excp_flush   = eval && has_excp;
   assign ertn_flush   = eval && !has_excp && h_ertn;
   assign flush_now    = excp_flush || ertn_flush;
   assign csr_req      = eval && !has_excp && !h_ertn && is_csr;
   assign plain_commit = eval && !has_excp && !h_ertn && !is_csr;
   assign csr_commit   = head_valid && (state_reg == S_CSR_WAIT) && csr_rvalid;
   assign commit       = plain_commit || csr_commit;

   assign in_ready     = !reset && !full && !flush_now;
   assign push         = in_valid && in_ready;

   always_comb begin
      excp_idx_c = '0;
      for (int i = 0; i < EXC_W; i++)
         if (h_excp[i]) excp_idx_c = IDX_W'(i);
   end

   assign excp_idx  = excp_flush ? excp_idx_c : '0;
   assign epc       = flush_now ? h_pc : '0;

   // CSR address/data stay stable for the whole access, not just the request cycle.
   assign csr_active = csr_req || (head_valid && (state_reg == S_CSR_WAIT));
   assign csr_we     = csr_active && h_csr_we;
   assign csr_num    = csr_active ? h_csr_num : '0;
   assign csr_wdata  = csr_active ? h_csr_wdata : '0;

   assign rf_we    = commit && h_gr_we && (h_dest != 5'd0);
   assign rf_waddr = rf_we ? h_dest : 5'd0;
   assign rf_wdata = !rf_we ? '0 :
                     ((state_reg == S_CSR_WAIT) && h_res_csr) ? csr_rdata : h_result;

   assign fwd_valid   = head_valid && h_gr_we && (h_dest != 5'd0);
   assign fwd_dest    = head_valid ? h_dest : 5'd0;
   assign fwd_data    = head_valid ? h_result : '0;
   assign fwd_pending = head_valid && h_res_csr;

   assign retire_cnt  = retire_cnt_reg;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= in_bus;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         state_reg      <= S_IDLE;
         retire_cnt_reg <= '0;
      end else begin
         if (flush_now) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (commit) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !commit)      count_reg <= count_reg + 1'b1;
            else if (!push && commit) count_reg <= count_reg - 1'b1;
         end
         if (csr_req)         state_reg <= S_CSR_WAIT;
         else if (csr_commit) state_reg <= S_IDLE;
         if (commit || ertn_flush) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: inputs change 1 time unit after each rising edge and
// outputs are checked 2 units later, mid-cycle.
module tb_wb_commit_unit;

   localparam int IN_W = 3*32 + 16 + 23;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_bus;
   logic            csr_req;
   logic            csr_we;
   logic [13:0]     csr_num;
   logic [31:0]     csr_wdata;
   logic            csr_rvalid;
   logic [31:0]     csr_rdata;
   logic            excp_flush;
   logic [3:0]      excp_idx;
   logic            ertn_flush;
   logic [31:0]     epc;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [31:0]     rf_wdata;
   logic            fwd_valid;
   logic [4:0]      fwd_dest;
   logic [31:0]     fwd_data;
   logic            fwd_pending;
   logic [63:0]     retire_cnt;

   int checks = 0;
   int errors = 0;

   wb_commit_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
      .csr_req(csr_req), .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata),
      .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .excp_flush(excp_flush),
      .excp_idx(excp_idx), .ertn_flush(ertn_flush), .epc(epc), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
      .fwd_data(fwd_data), .fwd_pending(fwd_pending), .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IN_W-1:0] mk(input logic [31:0] pc, input logic [31:0] result,
                                          input logic [4:0] dest, input logic gr_we,
                                          input logic res_csr, input logic ertn,
                                          input logic cwe, input logic [13:0] cnum,
                                          input logic [31:0] cwd, input logic [15:0] excp);
      return {excp, cwd, cnum, cwe, ertn, res_csr, gr_we, dest, result, pc};
   endfunction

   function automatic logic [IN_W-1:0] plain(input logic [31:0] pc, input logic [31:0] result,
                                             input logic [4:0] dest);
      return mk(pc, result, dest, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 16'd0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; caller drives inputs, then calls settle() before checking.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bus = '0; csr_rvalid = 1'b0; csr_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      settle();
      $display("reset held: in_ready=%0b retire_cnt=%0d", in_ready, retire_cnt);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_retire_cnt", retire_cnt, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_csr_req", csr_req, 0);
      next_cycle(); reset = 1'b0; settle();
      chk("post_rst_in_ready", in_ready, 1);

      // Plain stream: four back-to-back pushes, one commit per cycle
      next_cycle(); in_valid = 1'b1; in_bus = plain(32'h1c000000, 32'h11, 5'd5); settle();
      $display("plain push 0x11");
      chk("plain_c0_rf_we", rf_we, 0);
      chk("plain_c0_in_ready", in_ready, 1);
      next_cycle(); in_bus = plain(32'h1c000004, 32'h22, 5'd5); settle();
      $display("plain push 0x22, commit rf_we=%0b wdata=%0h", rf_we, rf_wdata);
      chk("plain_c1_rf_we", rf_we, 1);
      chk("plain_c1_waddr", rf_waddr, 5);
      chk("plain_c1_wdata", rf_wdata, 32'h11);
      chk("plain_c1_in_ready", in_ready, 1);
      chk("plain_c1_fwd_data", fwd_data, 32'h11);
      next_cycle(); in_bus = plain(32'h1c000008, 32'h33, 5'd5); settle();
      $display("plain push 0x33, commit wdata=%0h", rf_wdata);
      chk("plain_c2_wdata", rf_wdata, 32'h22);
      chk("plain_c2_in_ready", in_ready, 1);
      next_cycle(); in_bus = plain(32'h1c00000c, 32'h44, 5'd5); settle();
      $display("plain push 0x44, commit wdata=%0h", rf_wdata);
      chk("plain_c3_wdata", rf_wdata, 32'h33);
      chk("plain_c3_in_ready", in_ready, 1);
      next_cycle(); in_valid = 1'b0; settle();
      $display("plain commit wdata=%0h retire_cnt=%0d", rf_wdata, retire_cnt);
      chk("plain_c4_rf_we", rf_we, 1);
      chk("plain_c4_wdata", rf_wdata, 32'h44);
      chk("plain_c4_retire", retire_cnt, 3);
      next_cycle(); settle();
      chk("plain_c5_rf_we", rf_we, 0);
      chk("plain_retire", retire_cnt, 4);

      // dest 0 never writes the regfile but still retires
      next_cycle(); in_valid = 1'b1; in_bus = plain(32'h1c000010, 32'hdead, 5'd0); settle();
      next_cycle(); in_valid = 1'b0; settle();
      $display("dest0 commit rf_we=%0b fwd_valid=%0b", rf_we, fwd_valid);
      chk("dest0_rf_we", rf_we, 0);
      chk("dest0_fwd_valid", fwd_valid, 0);
      next_cycle(); settle();
      chk("dest0_retire", retire_cnt, 5);

      // CSR read, response three cycles after the request
      next_cycle(); in_valid = 1'b1;
      in_bus = mk(32'h1c000020, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 14'h005, 32'h0, 16'h0);
      settle();
      next_cycle(); in_bus = plain(32'h1c000024, 32'h55, 5'd8); settle();
      $display("csr request csr_req=%0b csr_num=%0h", csr_req, csr_num);
      chk("csr_c1_req", csr_req, 1);
      chk("csr_c1_num", csr_num, 14'h005);
      chk("csr_c1_pending", fwd_pending, 1);
      chk("csr_c1_in_ready", in_ready, 1);
      next_cycle(); in_bus = plain(32'h1c000028, 32'h66, 5'd9); settle();
      chk("csr_c2_req", csr_req, 0);
      chk("csr_c2_in_ready", in_ready, 0);
      chk("csr_c2_rf_we", rf_we, 0);
      chk("csr_c2_pending", fwd_pending, 1);
      next_cycle(); settle();
      chk("csr_c3_req", csr_req, 0);
      chk("csr_c3_in_ready", in_ready, 0);
      next_cycle(); csr_rvalid = 1'b1; csr_rdata = 32'hcafe; settle();
      $display("csr response rf_we=%0b waddr=%0d wdata=%0h", rf_we, rf_waddr, rf_wdata);
      chk("csr_c4_rf_we", rf_we, 1);
      chk("csr_c4_waddr", rf_waddr, 7);
      chk("csr_c4_wdata", rf_wdata, 32'hcafe);
      chk("csr_c4_pending", fwd_pending, 1);
      chk("csr_c4_in_ready", in_ready, 0);
      chk("csr_c4_req", csr_req, 0);
      next_cycle(); csr_rdata = 32'hbeef; settle();
      $display("plain after csr wdata=%0h", rf_wdata);
      chk("csr_c5_wdata", rf_wdata, 32'h55);
      chk("csr_c5_waddr", rf_waddr, 8);
      chk("csr_c5_in_ready", in_ready, 1);
      chk("csr_c5_retire", retire_cnt, 6);
      next_cycle(); in_valid = 1'b0; csr_rvalid = 1'b0; settle();
      chk("csr_c6_wdata", rf_wdata, 32'h66);
      next_cycle(); settle();
      chk("csr_retire", retire_cnt, 8);

      // Exception on the second of three entries
      next_cycle(); in_valid = 1'b1; in_bus = plain(32'h1c000004, 32'h77, 5'd10); settle();
      next_cycle();
      in_bus = mk(32'h1c000008, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 16'h0041);
      settle();
      chk("exc_c1_rf_we", rf_we, 1);
      next_cycle(); in_bus = plain(32'h1c00000c, 32'h88, 5'd11); settle();
      $display("exception flush=%0b idx=%0d epc=%0h", excp_flush, excp_idx, epc);
      chk("exc_flush", excp_flush, 1);
      chk("exc_idx", excp_idx, 6);
      chk("exc_epc", epc, 32'h1c000008);
      chk("exc_in_ready", in_ready, 0);
      chk("exc_rf_we", rf_we, 0);
      next_cycle(); in_valid = 1'b0; settle();
      chk("exc_after_flush", excp_flush, 0);
      chk("exc_after_fwd", fwd_valid, 0);
      chk("exc_after_rf_we", rf_we, 0);
      chk("exc_retire", retire_cnt, 9);
      next_cycle(); settle();
      chk("exc_dropped_rf_we", rf_we, 0);

      // ERTN behind a CSR write, with a concurrent in_valid held throughout
      next_cycle(); in_valid = 1'b1;
      in_bus = mk(32'h1c0000fc, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h006, 32'h1234, 16'h0);
      settle();
      next_cycle();
      in_bus = mk(32'h1c000100, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 16'h0);
      settle();
      $display("csr write csr_req=%0b we=%0b wdata=%0h", csr_req, csr_we, csr_wdata);
      chk("ertn_csr_req", csr_req, 1);
      chk("ertn_csr_we", csr_we, 1);
      chk("ertn_csr_num", csr_num, 14'h006);
      chk("ertn_csr_wdata", csr_wdata, 32'h1234);
      next_cycle(); in_bus = plain(32'h1c000104, 32'h99, 5'd12); csr_rvalid = 1'b1; settle();
      chk("ertn_full_in_ready", in_ready, 0);
      chk("ertn_csrw_rf_we", rf_we, 0);
      next_cycle(); csr_rvalid = 1'b0; settle();
      $display("ertn flush=%0b epc=%0h in_ready=%0b", ertn_flush, epc, in_ready);
      chk("ertn_flush", ertn_flush, 1);
      chk("ertn_epc", epc, 32'h1c000100);
      chk("ertn_in_ready", in_ready, 0);
      chk("ertn_no_excp", excp_flush, 0);
      chk("ertn_rf_we", rf_we, 0);
      next_cycle(); in_valid = 1'b0; settle();
      chk("ertn_after_flush", ertn_flush, 0);
      chk("ertn_empty_fwd", fwd_valid, 0);
      chk("ertn_retire", retire_cnt, 11);
      next_cycle(); settle();
      chk("ertn_dropped_rf_we", rf_we, 0);

      // Reset while waiting for a CSR response; the late response is ignored
      next_cycle(); in_valid = 1'b1;
      in_bus = mk(32'h1c000200, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 14'h007, 32'h0, 16'h0);
      settle();
      next_cycle(); in_valid = 1'b0; settle();
      chk("rstw_csr_req", csr_req, 1);
      next_cycle(); reset = 1'b1; settle();
      chk("rstw_in_ready", in_ready, 0);
      chk("rstw_pending", fwd_pending, 0);
      chk("rstw_csr_num", csr_num, 0);
      next_cycle(); reset = 1'b0; csr_rvalid = 1'b1; csr_rdata = 32'hbad; settle();
      $display("late csr response rf_we=%0b retire_cnt=%0d", rf_we, retire_cnt);
      chk("rstw_late_rf_we", rf_we, 0);
      chk("rstw_retire", retire_cnt, 0);
      chk("rstw_fwd_valid", fwd_valid, 0);
      chk("rstw_in_ready_after", in_ready, 1);
      chk("rstw_csr_req_after", csr_req, 0);
      next_cycle(); csr_rvalid = 1'b0; settle();
      chk("rstw_final_rf_we", rf_we, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Parametrised writeback/commit stage. Buffers memory-stage results in a DEPTH-entry FIFO and retires one instruction at a time to the register file. CSR accesses go through a variable-latency request/response port. Precise exception and ERTN flushes are raised from the buffer head, and a registered retired-instruction counter is kept. Sits between the memory stage and the regfile/CSR unit, and supplies head-of-buffer forwarding to decode.

## Interface
- DATA_W, 32, datapath width (pc, result, CSR data)
- EXC_W, 16, exception vector width; bit EXC_W-1 is highest priority
- DEPTH, 2, input FIFO entries; power of two, >=2
- CNT_W, 64, retire counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  memory stage presents an entry
- in_ready  out  1  entry accepted on clk edge when in_valid&in_ready
- in_bus  in  IN_W=3*DATA_W+EXC_W+23  packed entry, layout in Operation
- csr_req  out  1  one-cycle CSR access request for head entry
- csr_we  out  1  CSR write enable (qualified by csr_req)
- csr_num  out  14  CSR address
- csr_wdata  out  DATA_W  pre-masked CSR write data
- csr_rvalid  in  1  CSR response; read data valid this cycle
- csr_rdata  in  DATA_W  CSR read data
- excp_flush  out  1  one-cycle exception flush
- excp_idx  out  $clog2(EXC_W)  index of highest set exception bit
- ertn_flush  out  1  one-cycle ERTN flush
- epc  out  DATA_W  pc of the head entry; valid with either flush
- rf_we  out  1  regfile write strobe
- rf_waddr  out  5  regfile write address
- rf_wdata  out  DATA_W  regfile write data
- fwd_valid  out  1  head holds a pending write (gr_we, dest!=0)
- fwd_dest  out  5  head destination
- fwd_data  out  DATA_W  head result
- fwd_pending  out  1  head data not yet known (res_from_csr); decode must stall
- retire_cnt  out  CNT_W  registered count of retired instructions

## Operation
- in_bus layout, LSB first: pc[DATA_W], result[DATA_W], dest[5], gr_we, res_from_csr, ertn, csr_we, csr_num[14], csr_wdata[DATA_W], excp_vec[EXC_W].
- FIFO with circular pointers plus a count; full when count==DEPTH.
- in_ready = !reset & !full & !flush_now. There is no push-while-full bypass, even when a pop happens in the same cycle.
- States:
  - IDLE: evaluates the head entry when the FIFO is non-empty.
  - CSR_WAIT: waiting for csr_rvalid.
- IDLE, head excp_vec!=0:
  - Assert excp_flush with excp_idx = highest set bit and epc = head pc.
  - No rf or CSR write; retire_cnt unchanged.
  - Entire FIFO cleared; same-cycle input dropped because in_ready=0.
- IDLE, head ertn (no exception):
  - Assert ertn_flush with epc = head pc.
  - FIFO cleared; retire_cnt+1.
  - No rf write.
- IDLE, head csr_we|res_from_csr:
  - csr_req=1 for one cycle; go to CSR_WAIT.
  - The entry stays at the head.
- CSR_WAIT:
  - Hold all outputs; no new csr_req.
  - On csr_rvalid: rf_we = gr_we & dest!=0, rf_wdata = res_from_csr ? csr_rdata : result.
  - Then pop, retire_cnt+1, and return to IDLE.
- IDLE, plain head:
  - rf_we = gr_we & dest!=0, rf_wdata = result.
  - Pop, retire_cnt+1.
- rf_we is never asserted for dest 0.
- retire_cnt wraps modulo 2^CNT_W.
- Pushes are accepted in any state when in_ready=1.

## Timing
- Entry pushed at edge t is evaluated as head in cycle t+1 at the earliest. Plain commit latency is 1 cycle; CSR commit takes 1 + response latency.
- csr_rvalid is ignored in IDLE. The earliest legal response is the cycle after csr_req.
- rf_*, flush, csr_* and fwd_* outputs are combinational from head and state. retire_cnt is registered and updates on the edge closing the commit cycle.
- Reset values:
  - All outputs 0; in_ready 0 during reset and 1 in the first cycle after.
  - FIFO empty, state IDLE, retire_cnt 0.
- Reset asserted in CSR_WAIT abandons the access; a late csr_rvalid afterwards is ignored.

## Test plan
- Plain stream: 4 back-to-back entries, dest=5, result=0x11..0x44 -> rf_we in consecutive cycles starting 1 cycle after first push; retire_cnt=4; in_ready never drops with DEPTH=2.
- dest=0, gr_we=1, result=0xDEAD -> rf_we=0, retire_cnt+1.
- CSR read: res_from_csr=1, dest=7, csr_rvalid 3 cycles after csr_req with rdata 0xCAFE -> single csr_req, rf_wdata=0xCAFE; fwd_pending=1 until the commit; in_ready=0 once the FIFO fills.
- Exception: excp_vec=0x0041 on entry 2 of 3 (pc 0x1c000008) -> excp_flush one cycle, excp_idx=6, epc=0x1c000008; entry 3 discarded; retire_cnt=1.
- ERTN with full FIFO plus a concurrent in_valid -> ertn_flush, FIFO empty next cycle, concurrent input not accepted; retire_cnt+1.
- Reset mid CSR_WAIT, then csr_rvalid -> no rf_we; all outputs 0; retire_cnt 0.
